jelly_video_resize_double: RTL and testbench

//  2x nearest-neighbour upscaler on AXI4-Stream video; inverse of the half-resize (decimation) path.

---
 rtl/jelly_video_resize_double.sv | 214 +++++++++++++++++++++
 tb/tb_jelly_video_resize_double.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_video_resize_double.sv
// 2x nearest-neighbour upscaler for AXI4-Stream video: pixels doubled horizontally, lines replayed from a buffer.
// Optional sticky line-overflow flag: define JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN.
module jelly_video_resize_double #(
  parameter int COMPONENT_NUM       = 3,
  parameter int DATA_WIDTH          = 8,
  parameter int AXI4S_TUSER_WIDTH   = 1,
  parameter int AXI4S_TDATA_WIDTH   = COMPONENT_NUM * DATA_WIDTH,
  parameter int MAX_X_NUM           = 4096,
  parameter     RAM_TYPE            = (MAX_X_NUM > 128) ? "block" : "distributed",
  parameter bit INIT_PARAM_H_ENABLE = 1'b1,
  parameter bit INIT_PARAM_V_ENABLE = 1'b1
) (
  input  logic                         reset,
  input  logic                         clk,
  input  logic                         cke,
  input  logic                         param_h_enable,
  input  logic                         param_v_enable,
  input  logic [AXI4S_TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                         s_axi4s_tlast,
  input  logic [AXI4S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                         s_axi4s_tvalid,
  output logic                         s_axi4s_tready,
  output logic [AXI4S_TUSER_WIDTH-1:0] m_axi4s_tuser,
  output logic                         m_axi4s_tlast,
  output logic [AXI4S_TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                         m_axi4s_tvalid,
  input  logic                         m_axi4s_tready
`ifdef JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN
  , output logic                       overflow
`endif
);

  localparam int AW = (MAX_X_NUM > 1) ? $clog2(MAX_X_NUM) : 1;
  localparam int XW = $clog2(MAX_X_NUM + 1);

  typedef enum logic {ST_PASS, ST_REPEAT} state_t;

  state_t                         state_q, state_d;
  logic [XW-1:0]                  x_q, x_d, len_q, len_d;
  logic [AW-1:0]                  rdIdx_q, rdIdx_d;
  logic                           dup_q, dup_d, dupLast_q, dupLast_d;
  logic                           rphase_q, rphase_d, primed_q, primed_d;
  logic                           hEn_q, hEn_d, vEn_q, vEn_d;
  logic [AXI4S_TDATA_WIDTH-1:0]   rdData_q;
  logic                           mValid_q, mLast_q;
  logic [AXI4S_TUSER_WIDTH-1:0]   mUser_q;
  logic [AXI4S_TDATA_WIDTH-1:0]   mData_q;

  logic                           loadable, sAccept, wrEn, hEff, vEff;
  logic                           emitValid, emitLast, rdLast;
  logic [AXI4S_TUSER_WIDTH-1:0]   emitUser;
  logic [AXI4S_TDATA_WIDTH-1:0]   emitData;

  assign loadable       = !mValid_q || m_axi4s_tready;
  assign s_axi4s_tready = (state_q == ST_PASS) && loadable && !dup_q;
  assign sAccept        = s_axi4s_tvalid && s_axi4s_tready;
  assign wrEn           = sAccept && (x_q < XW'(MAX_X_NUM));
  assign rdLast         = (XW'(rdIdx_q) == len_q - XW'(1));

  assign m_axi4s_tvalid = mValid_q;
  assign m_axi4s_tuser  = mUser_q;
  assign m_axi4s_tlast  = mLast_q;
  assign m_axi4s_tdata  = mData_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    len_d     = len_q;
    rdIdx_d   = rdIdx_q;
    dup_d     = dup_q;
    dupLast_d = dupLast_q;
    rphase_d  = rphase_q;
    primed_d  = primed_q;
    hEn_d     = hEn_q;
    vEn_d     = vEn_q;
    hEff      = hEn_q;
    vEff      = vEn_q;
    emitValid = 1'b0;
    emitData  = mData_q;
    emitUser  = '0;
    emitLast  = 1'b0;

    // a frame-start pixel applies freshly sampled enables to itself
    if (sAccept && s_axi4s_tuser[0]) begin
      hEff  = param_h_enable;
      vEff  = param_v_enable;
      hEn_d = param_h_enable;
      vEn_d = param_v_enable;
    end

    // the first replay cycle only fetches buffer[0], giving the final pass write time to land
    if (state_q == ST_REPEAT && !primed_q) primed_d = 1'b1;

    if (dup_q) begin
      emitValid = 1'b1;
      emitLast  = dupLast_q;
      if (loadable) dup_d = 1'b0;
    end else begin
      case (state_q)
        ST_PASS: begin
          if (sAccept) begin
            emitValid = 1'b1;
            emitData  = s_axi4s_tdata;
            emitUser  = s_axi4s_tuser;
            emitLast  = s_axi4s_tlast && !hEff;
            dup_d     = hEff;
            dupLast_d = s_axi4s_tlast;
            if (s_axi4s_tlast) begin
              x_d   = '0;
              len_d = (x_q < XW'(MAX_X_NUM)) ? x_q + XW'(1) : XW'(MAX_X_NUM);
              if (vEff) begin
                state_d  = ST_REPEAT;
                rdIdx_d  = '0;
                rphase_d = 1'b0;
                primed_d = 1'b0;
              end
            end else if (x_q < XW'(MAX_X_NUM)) begin
              x_d = x_q + XW'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (primed_q) begin
            emitValid = 1'b1;
            emitData  = rdData_q;
            if (!hEn_q || rphase_q) begin
              emitLast = rdLast;
              if (loadable) begin
                rphase_d = 1'b0;
                if (rdLast) begin
                  state_d  = ST_PASS;
                  rdIdx_d  = '0;
                  primed_d = 1'b0;
                end else begin
                  rdIdx_d = rdIdx_q + AW'(1);
                end
              end
            end else if (loadable) begin
              rphase_d = 1'b1;
            end
          end
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_PASS;
      x_q       <= '0;
      len_q     <= '0;
      rdIdx_q   <= '0;
      dup_q     <= 1'b0;
      dupLast_q <= 1'b0;
      rphase_q  <= 1'b0;
      primed_q  <= 1'b0;
      hEn_q     <= INIT_PARAM_H_ENABLE;
      vEn_q     <= INIT_PARAM_V_ENABLE;
      mValid_q  <= 1'b0;
      mUser_q   <= '0;
      mLast_q   <= 1'b0;
      mData_q   <= '0;
    end else if (cke) begin
      state_q   <= state_d;
      x_q       <= x_d;
      len_q     <= len_d;
      rdIdx_q   <= rdIdx_d;
      dup_q     <= dup_d;
      dupLast_q <= dupLast_d;
      rphase_q  <= rphase_d;
      primed_q  <= primed_d;
      hEn_q     <= hEn_d;
      vEn_q     <= vEn_d;
      if (loadable) begin
        mValid_q <= emitValid;
        if (emitValid) begin
          mUser_q <= emitUser;
          mLast_q <= emitLast;
          mData_q <= emitData;
        end
      end
    end
  end

  // rdData_q tracks buffer[rdIdx_q], so a stalled output never loses its prefetched pixel
  if (RAM_TYPE == "block") begin : gBlockRam
    (* ram_style = "block" *) logic [AXI4S_TDATA_WIDTH-1:0] mem [MAX_X_NUM];
    always_ff @(posedge clk) begin
      if (cke) begin
        if (wrEn) mem[x_q[AW-1:0]] <= s_axi4s_tdata;
        rdData_q <= mem[rdIdx_d];
      end
    end
  end else begin : gDistRam
    (* ram_style = "distributed" *) logic [AXI4S_TDATA_WIDTH-1:0] mem [MAX_X_NUM];
    always_ff @(posedge clk) begin
      if (cke) begin
        if (wrEn) mem[x_q[AW-1:0]] <= s_axi4s_tdata;
        rdData_q <= mem[rdIdx_d];
      end
    end
  end

`ifdef JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN
  logic overflow_q;
  assign overflow = overflow_q;
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else if (cke && sAccept && x_q == XW'(MAX_X_NUM)) overflow_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_jelly_video_resize_double.sv
// Self-checking bench for jelly_video_resize_double against a frame-level upscaling model.
// Overflow checks are compiled in with JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN.
module tb_jelly_video_resize_double;
  localparam int MAXX = 16;
  localparam int TD   = 24;

  logic          clk = 1'b0;
  logic          reset, cke, hParam, vParam;
  logic [0:0]    sUser, mUser;
  logic          sLast, sValid, sReady, mLast, mValid, mReady;
  logic [TD-1:0] sData, mData;
`ifdef JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN
  logic          overflow;
`endif

  jelly_video_resize_double #(.COMPONENT_NUM(3), .DATA_WIDTH(8), .AXI4S_TUSER_WIDTH(1), .MAX_X_NUM(MAXX)) dut (
    .reset(reset), .clk(clk), .cke(cke),
    .param_h_enable(hParam), .param_v_enable(vParam),
    .s_axi4s_tuser(sUser), .s_axi4s_tlast(sLast), .s_axi4s_tdata(sData),
    .s_axi4s_tvalid(sValid), .s_axi4s_tready(sReady),
    .m_axi4s_tuser(mUser), .m_axi4s_tlast(mLast), .m_axi4s_tdata(mData),
    .m_axi4s_tvalid(mValid), .m_axi4s_tready(mReady)
`ifdef JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TD-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  beat_t inQ[$], expQ[$], gotQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;
  int    frozenChanges;
  bit    timedOut;

  // Model: every pixel appears twice when h is on; every line is followed by
  // a replay of its first MAXX pixels when v is on; frame start only on the very first output.
  task automatic addFrames(input int nFrames, input int w, input int h, input bit hEn, input bit vEn,
                           input bit randData, input int base);
    logic [TD-1:0] line[$];
    logic [TD-1:0] d;
    int            n;
    for (int f = 0; f < nFrames; f++) begin
      for (int y = 0; y < h; y++) begin
        line = {};
        for (int x = 0; x < w; x++) begin
          d = randData ? TD'($urandom) : TD'(base + f * w * h + y * w + x + 1);
          line.push_back(d);
          inQ.push_back(beat_t'{data: d, user: (x == 0 && y == 0), last: (x == w - 1)});
          expQ.push_back(beat_t'{data: d, user: (x == 0 && y == 0), last: (x == w - 1) && !hEn});
          if (hEn) expQ.push_back(beat_t'{data: d, user: 1'b0, last: (x == w - 1)});
        end
        if (vEn) begin
          n = (w < MAXX) ? w : MAXX;
          for (int x = 0; x < n; x++) begin
            expQ.push_back(beat_t'{data: line[x], user: 1'b0, last: (x == n - 1) && !hEn});
            if (hEn) expQ.push_back(beat_t'{data: line[x], user: 1'b0, last: (x == n - 1)});
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input int validPct, input int readyPct, input int stallAt, input int stallLen);
    int                cycle;
    bit                sAcc, mAcc;
    beat_t             mb;
    logic [TD+2:0]     snap;
    cycle = 0;
    gotQ = {};
    frozenChanges = 0;
    timedOut = 1'b0;
    while (inQ.size() > 0 || gotQ.size() < expQ.size()) begin
      if (cycle >= 5000) begin
        timedOut = 1'b1;
        break;
      end
      cke = !(cycle >= stallAt && cycle < stallAt + stallLen);
      if (inQ.size() > 0 && $urandom_range(99) < validPct) begin
        sValid = 1'b1;
        sData  = inQ[0].data;
        sUser  = inQ[0].user;
        sLast  = inQ[0].last;
      end else begin
        sValid = 1'b0;
      end
      mReady = ($urandom_range(99) < readyPct);
      #1;
      sAcc = cke && sValid && sReady;
      mAcc = cke && mValid && mReady;
      mb   = beat_t'{data: mData, user: mUser[0], last: mLast};
      snap = {mValid, mData, mUser, mLast};
      @(posedge clk);
      #1;
      if (!cke && snap != {mValid, mData, mUser, mLast}) frozenChanges++;
      if (sAcc) void'(inQ.pop_front());
      if (mAcc) gotQ.push_back(mb);
      cycle++;
    end
    sValid = 1'b0;
    mReady = 1'b1;
    cke    = 1'b1;
    repeat (20) begin
      #1;
      if (mValid) gotQ.push_back(beat_t'{data: mData, user: mUser[0], last: mLast});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset  = 1'b1;
    cke    = 1'b1;
    sValid = 1'b0;
    sUser  = '0;
    sLast  = 1'b0;
    sData  = '0;
    mReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    testsRun++;
    if (mValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_tvalid got %b want 0", mValid); end
    testsRun++;
    if (mData !== '0) begin testsFailed++; $display("[TB] FAIL reset_tdata got %h want 0", mData); end
    testsRun++;
    if ({mUser, mLast} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_flags got %b%b want 00", mUser, mLast); end
    testsRun++;
    if (sReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_tready got %b want 1", sReady); end
`ifdef JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN
    testsRun++;
    if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
`endif
  endtask

  task automatic test_modes();
    for (int m = 3; m >= 0; m--) begin
      hParam = m[1];
      vParam = m[0];
      inQ = {};
      expQ = {};
      addFrames(1, 4, 2, m[1], m[0], 1'b0, 0);
      applyStimulus(100, 100, -100, 0);
      testsRun++;
      if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL modes_h%0d_v%0d timeout got %b want 0", m[1], m[0], timedOut); end
      testsRun++;
      if (gotQ.size() !== expQ.size()) begin
        testsFailed++;
        $display("[TB] FAIL modes_h%0d_v%0d count got %0d want %0d", m[1], m[0], gotQ.size(), expQ.size());
      end
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
        testsRun++;
        if (gotQ[i] !== expQ[i]) begin
          testsFailed++;
          $display("[TB] FAIL modes_h%0d_v%0d beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", m[1], m[0], i,
                   gotQ[i].data, gotQ[i].user, gotQ[i].last, expQ[i].data, expQ[i].user, expQ[i].last);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepted;
    hParam = 1'b0;
    vParam = 1'b0;
    accepted = 0;
    mReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sValid = 1'b1;
      sData  = TD'(24'h100000 + i * 24'h010203);
      sUser  = (i == 0);
      sLast  = (i == 7);
      #1;
      if (sReady) accepted++;
      @(posedge clk);
      #1;
      testsRun++;
      if (mValid !== 1'b1 || mData !== TD'(24'h100000 + i * 24'h010203) || mLast !== (i == 7)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_latency pix %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, mValid, mData, mLast,
                 TD'(24'h100000 + i * 24'h010203), (i == 7));
      end
    end
    sValid = 1'b0;
    testsRun++;
    if (accepted !== 8) begin testsFailed++; $display("[TB] FAIL b2b_throughput got %0d want 8", accepted); end
    @(posedge clk);
    #1;
    testsRun++;
    if (mValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_drain got %b want 0", mValid); end
  endtask

  task automatic test_random();
    hParam = 1'b1;
    vParam = 1'b1;
    inQ = {};
    expQ = {};
    addFrames(3, 16, 4, 1'b1, 1'b1, 1'b1, 0);
    applyStimulus(70, 50, -100, 0);
    testsRun++;
    if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL random_timeout got %b want 0", timedOut); end
    testsRun++;
    if (gotQ.size() !== expQ.size()) begin
      testsFailed++;
      $display("[TB] FAIL random_count got %0d want %0d", gotQ.size(), expQ.size());
    end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin
        testsFailed++;
        $display("[TB] FAIL random beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 gotQ[i].data, gotQ[i].user, gotQ[i].last, expQ[i].data, expQ[i].user, expQ[i].last);
      end
    end
  endtask

  task automatic test_cke();
    hParam = 1'b1;
    vParam = 1'b1;
    inQ = {};
    expQ = {};
    addFrames(1, 4, 2, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(100, 100, 6, 5);
    testsRun++;
    if (frozenChanges !== 0) begin testsFailed++; $display("[TB] FAIL cke_freeze changes got %0d want 0", frozenChanges); end
    testsRun++;
    if (gotQ.size() !== expQ.size()) begin
      testsFailed++;
      $display("[TB] FAIL cke_count got %0d want %0d", gotQ.size(), expQ.size());
    end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin
        testsFailed++;
        $display("[TB] FAIL cke beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 gotQ[i].data, gotQ[i].user, gotQ[i].last, expQ[i].data, expQ[i].user, expQ[i].last);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    bit acc;
    int waitCycles;
    hParam = 1'b1;
    vParam = 1'b1;
    mReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sValid = 1'b1;
      sData  = TD'(24'h0A0000 + i);
      sUser  = (i == 0);
      sLast  = (i == 3);
      acc = 1'b0;
      waitCycles = 0;
      while (!acc && waitCycles < 20) begin
        #1;
        acc = sReady;
        @(posedge clk);
        #1;
        waitCycles++;
      end
      testsRun++;
      if (acc !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrep_accept pix %0d got %b want 1", i, acc); end
    end
    sValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    testsRun++;
    if (mValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrep_tvalid got %b want 0", mValid); end
    testsRun++;
    if (sReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrep_tready got %b want 1", sReady); end
    inQ = {};
    expQ = {};
    addFrames(1, 2, 1, 1'b1, 1'b1, 1'b0, 100);
    applyStimulus(100, 100, -100, 0);
    testsRun++;
    if (gotQ.size() !== 8) begin testsFailed++; $display("[TB] FAIL midrep_count got %0d want 8", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin
        testsFailed++;
        $display("[TB] FAIL midrep beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 gotQ[i].data, gotQ[i].user, gotQ[i].last, expQ[i].data, expQ[i].user, expQ[i].last);
      end
    end
  endtask

  task automatic test_overflow();
`ifdef JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN
    testsRun++;
    if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL overflow_pre got %b want 0", overflow); end
`endif
    hParam = 1'b1;
    vParam = 1'b1;
    inQ = {};
    expQ = {};
    addFrames(1, MAXX + 4, 1, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(100, 100, -100, 0);
    testsRun++;
    if (gotQ.size() !== 2 * (MAXX + 4) + 2 * MAXX) begin
      testsFailed++;
      $display("[TB] FAIL overflow_count got %0d want %0d", gotQ.size(), 2 * (MAXX + 4) + 2 * MAXX);
    end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin
        testsFailed++;
        $display("[TB] FAIL overflow beat %0d got d=%h u=%b l=%b want d=%h u=%b l=%b", i,
                 gotQ[i].data, gotQ[i].user, gotQ[i].last, expQ[i].data, expQ[i].user, expQ[i].last);
      end
    end
`ifdef JELLY_VIDEO_RESIZE_DOUBLE_OVERFLOW_EN
    testsRun++;
    if (overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL overflow_flag got %b want 1", overflow); end
`endif
  endtask

  initial begin
    hParam = 1'b1;
    vParam = 1'b1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_random();
    test_cke();
    test_reset_mid_repeat();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
